// File: rtl/instr_encoder.sv
// MIPS instruction encoder streaming one word per handshake into imem.
// Define BRANCH_DELAY_NOP_EN to follow each BEQ/BNE/J with a delay-slot NOP.
module instr_encoder #(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_AND  = 4'd2;
  localparam logic [3:0] K_OR   = 4'd3;
  localparam logic [3:0] K_SLT  = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_BNE  = 4'd8;
  localparam logic [3:0] K_ADDI = 4'd9;
  localparam logic [3:0] K_ORI  = 4'd10;
  localparam logic [3:0] K_J    = 4'd11;
  localparam logic [3:0] K_NOP  = 4'd12;

`ifdef BRANCH_DELAY_NOP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DLY  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;

  logic [31:0]         enc_word;
  logic                enc_ok;
  logic                accept;
  logic                wr_fire;
`ifdef BRANCH_DELAY_NOP_EN
  logic                enc_br;
`endif

  function automatic logic [31:0] r_word(
    input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d, input logic [5:0] f
  );
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_word(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im
  );
    return {op, s, t, im};
  endfunction

  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    unique case (req_kind)
      K_ADD:  enc_word = r_word(req_rs, req_rt, req_rd, 6'h20);
      K_SUB:  enc_word = r_word(req_rs, req_rt, req_rd, 6'h22);
      K_AND:  enc_word = r_word(req_rs, req_rt, req_rd, 6'h24);
      K_OR:   enc_word = r_word(req_rs, req_rt, req_rd, 6'h25);
      K_SLT:  enc_word = r_word(req_rs, req_rt, req_rd, 6'h2A);
      K_LW:   enc_word = i_word(6'h23, req_rs, req_rt, req_imm);
      K_SW:   enc_word = i_word(6'h2B, req_rs, req_rt, req_imm);
      K_BEQ:  enc_word = i_word(6'h04, req_rs, req_rt, req_imm);
      K_BNE:  enc_word = i_word(6'h05, req_rs, req_rt, req_imm);
      K_ADDI: enc_word = i_word(6'h08, req_rs, req_rt, req_imm);
      K_ORI:  enc_word = i_word(6'h0D, req_rs, req_rt, req_imm);
      K_J:    enc_word = {6'h02, req_target};
      K_NOP:  enc_word = 32'h0;
      default: enc_ok  = 1'b0;
    endcase
  end

`ifdef BRANCH_DELAY_NOP_EN
  always_comb begin
    enc_br = (req_kind == K_BEQ) ||
             (req_kind == K_BNE) ||
             (req_kind == K_J);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      addr_q  <= BASE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    accept  = req_valid && req_ready;
    wr_fire = wr_valid && wr_ready;
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    if (wr_fire) addr_d = addr_q + 1'b1;
    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (enc_ok) begin
            data_d  = enc_word;
            state_d = HOLD;
`ifdef BRANCH_DELAY_NOP_EN
            if (enc_br) state_d = DLY;
`endif
          end else begin
            // Illegal kind is swallowed; any word written this edge empties us.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (wr_fire) begin
          state_d = IDLE;
        end
      end
`ifdef BRANCH_DELAY_NOP_EN
      DLY: begin
        if (wr_fire) begin
          data_d  = 32'h0;
          state_d = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      data_d  = 32'h0;
      addr_d  = BASE;
      err_d   = 1'b0;
    end
  end

  always_comb begin
    wr_valid    = (state_q != IDLE);
    req_ready   = !wr_valid || wr_ready;
`ifdef BRANCH_DELAY_NOP_EN
    if (state_q == DLY) req_ready = 1'b0;
`endif
    wr_data     = data_q;
    wr_addr     = addr_q;
    err_illegal = err_q;
  end

endmodule
